lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_pkg.sv | 47 ++++
 rtl/lsu_ctrl_load_align.sv | 28 ++
 rtl/lsu_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared pipeline definitions: ALU op codes, memory op codes, access sizes and LSU state encodings.
`default_nettype none

package lsu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;

    localparam logic [3:0] MEM_OP_LD_B  = 4'd0;
    localparam logic [3:0] MEM_OP_LD_H  = 4'd1;
    localparam logic [3:0] MEM_OP_LD_W  = 4'd2;
    localparam logic [3:0] MEM_OP_LD_BU = 4'd3;
    localparam logic [3:0] MEM_OP_LD_HU = 4'd4;
    localparam logic [3:0] MEM_OP_ST_B  = 4'd5;
    localparam logic [3:0] MEM_OP_ST_H  = 4'd6;
    localparam logic [3:0] MEM_OP_ST_W  = 4'd7;
    localparam logic [3:0] MEM_OP_LL_W  = 4'd8;
    localparam logic [3:0] MEM_OP_SC_W  = 4'd9;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    function automatic logic [1:0] mem_op_size(input logic [3:0] op);
        case (op)
            MEM_OP_LD_B, MEM_OP_LD_BU, MEM_OP_ST_B: mem_op_size = SIZE_B;
            MEM_OP_LD_H, MEM_OP_LD_HU, MEM_OP_ST_H: mem_op_size = SIZE_H;
            default:                                mem_op_size = SIZE_W;
        endcase
    endfunction

    function automatic logic mem_op_is_store(input logic [3:0] op);
        mem_op_is_store = (op == MEM_OP_ST_B) || (op == MEM_OP_ST_H) ||
                          (op == MEM_OP_ST_W) || (op == MEM_OP_SC_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_load_align.sv
// lsu_load_align: shifts the returned word down to the accessed lane and extends it per load type.
`default_nettype none

module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = rdata >> {addr_lo, 3'b000};
        case (mem_op)
            MEM_OP_LD_B:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_OP_LD_BU: load_data = {24'd0, w_shifted[7:0]};
            MEM_OP_LD_H:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_OP_LD_HU: load_data = {16'd0, w_shifted[15:0]};
            default:      load_data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit driving an SRAM-like bus, with LL/SC llbit tracking.
// Optional alignment exceptions are enabled by defining LSU_ALE_CHECK_EN.
`default_nettype none

module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_mem_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        flush,
    input  logic        llbit_clr,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_ale,
    output logic [31:0] out_badv
);

    logic [2:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        llbit_q, llbit_d;

    logic        w_accept;
    logic        w_ale;
    logic        w_sc_fail;
    logic [1:0]  w_in_size;
    logic [31:0] w_req_addr;
    logic [31:0] w_load_data;
    logic        w_data_done;

    assign w_accept    = in_valid && (state_q == S_IDLE) && !flush;
    assign w_in_size   = mem_op_size(in_mem_op);
    assign w_sc_fail   = (in_mem_op == MEM_OP_SC_W) && !llbit_q;
    assign w_data_done = (state_q == S_WAIT) && data_sram_data_ok && !flush;

`ifdef LSU_ALE_CHECK_EN
    logic ale_q, ale_d;

    assign w_ale      = ((w_in_size == SIZE_H) && in_addr[0]) ||
                        ((w_in_size == SIZE_W) && (in_addr[1:0] != 2'b00));
    assign w_req_addr = in_addr;
    assign out_ale    = (state_q == S_RESP) && ale_q;
    assign out_badv   = out_ale ? addr_q : 32'd0;
`else
    // Without exception reporting, misaligned accesses are silently rounded down to the access size.
    assign w_ale      = 1'b0;
    assign w_req_addr = {in_addr[31:2],
                         (w_in_size == SIZE_W) ? 2'b00 :
                         (w_in_size == SIZE_H) ? {in_addr[1], 1'b0} : in_addr[1:0]};
    assign out_ale    = 1'b0;
    assign out_badv   = 32'd0;
`endif

    lsu_load_align u_load_align (
        .mem_op    (op_q),
        .addr_lo   (addr_q[1:0]),
        .rdata     (data_sram_rdata),
        .load_data (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            llbit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            llbit_q <= llbit_d;
        end
    end

`ifdef LSU_ALE_CHECK_EN
    always_comb begin
        ale_d = ale_q;
        if (w_accept) begin
            ale_d = w_ale;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_q <= 1'b0;
        end else begin
            ale_q <= ale_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_accept) state_d = (w_ale || w_sc_fail) ? S_RESP : S_REQ;
            S_REQ: begin
                if (flush) begin
                    state_d = data_sram_addr_ok ? S_DROP : S_IDLE;
                end else if (data_sram_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            // A flush coinciding with data_ok has nothing left to drain.
            S_WAIT: begin
                if (flush) begin
                    state_d = data_sram_data_ok ? S_IDLE : S_DROP;
                end else if (data_sram_data_ok) begin
                    state_d = S_RESP;
                end
            end
            S_DROP: if (data_sram_data_ok) state_d = S_IDLE;
            S_RESP: if (flush || out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        llbit_d = llbit_q;
        if (w_accept) begin
            op_d    = in_mem_op;
            addr_d  = w_req_addr;
            wdata_d = in_wdata;
            rdata_d = 32'd0;
        end
        if (w_data_done) begin
            if (op_q == MEM_OP_LL_W) llbit_d = 1'b1;
            if (op_q == MEM_OP_SC_W) llbit_d = 1'b0;
            if (op_q == MEM_OP_SC_W) begin
                rdata_d = 32'd1;
            end else if (mem_op_is_store(op_q)) begin
                rdata_d = 32'd0;
            end else begin
                rdata_d = w_load_data;
            end
        end
        if (llbit_clr) begin
            llbit_d = 1'b0;
        end
    end

    always_comb begin
        in_ready        = (state_q == S_IDLE);
        data_sram_req   = (state_q == S_REQ);
        out_valid       = (state_q == S_RESP);
        out_rdata       = out_valid ? rdata_q : 32'd0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'd0;
        data_sram_wstrb = 4'd0;
        data_sram_wdata = 32'd0;
        if (state_q == S_REQ) begin
            data_sram_wr   = mem_op_is_store(op_q);
            data_sram_size = mem_op_size(op_q);
            data_sram_addr = addr_q;
            case (mem_op_size(op_q))
                SIZE_B: begin
                    data_sram_wstrb = 4'b0001 << addr_q[1:0];
                    data_sram_wdata = {4{wdata_q[7:0]}};
                end
                SIZE_H: begin
                    data_sram_wstrb = 4'b0011 << addr_q[1:0];
                    data_sram_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    data_sram_wstrb = 4'b1111;
                    data_sram_wdata = wdata_q;
                end
            endcase
            if (!mem_op_is_store(op_q)) begin
                data_sram_wstrb = 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench with a random-latency SRAM slave and a transaction-level LSU model.
`default_nettype none

module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mem_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        llbit_clr;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_ale;
    logic [31:0] out_badv;

    lsu_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_mem_op         (in_mem_op),
        .in_addr           (in_addr),
        .in_wdata          (in_wdata),
        .flush             (flush),
        .llbit_clr         (llbit_clr),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_rdata         (out_rdata),
        .out_ale           (out_ale),
        .out_badv          (out_badv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        ale;
        logic [31:0] badv;
    } out_t;

    bus_t bus_q[$];
    out_t out_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   ref_llbit = 1'b0;
    bit   rand_ready = 1'b0;
    int   force_aok = -1;
    int   force_dok = -1;
    int   hs_len = 0;
    int   hs_count = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_1000) return 32'h8011_2233;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // SRAM slave: random (or forced) addr_ok and data_ok latencies; also checks each bus request.
    initial begin : slave
        int          acnt;
        int          aok_lim;
        int          dok_cnt;
        bit          pending;
        bit          prev_req;
        logic [31:0] pend_addr;
        logic [70:0] cur;
        logic [70:0] prev;
        bus_t        e;
        acnt = 0; aok_lim = 0; dok_cnt = 0; pending = 0; prev_req = 0;
        pend_addr = 0; prev = '0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            if (reset) begin
                pending = 0; acnt = 0; prev_req = 0;
            end else begin
                if (pending) begin
                    if (dok_cnt == 0) begin
                        data_sram_data_ok = 1'b1;
                        data_sram_rdata   = mem_word(pend_addr);
                        pending = 0;
                    end else begin
                        dok_cnt--;
                    end
                end
                if (data_sram_req) begin
                    cur = {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata};
                    if (prev_req) chk("req_fields_stable", cur, prev);
                    prev = cur;
                    if (!pending && !data_sram_data_ok) begin
                        if (acnt >= aok_lim) begin
                            data_sram_addr_ok = 1'b1;
                            pending   = 1;
                            pend_addr = data_sram_addr;
                            dok_cnt   = (force_dok >= 0) ? force_dok : int'($urandom_range(0, 3));
                            hs_len    = acnt + 1;
                            hs_count++;
                            acnt      = 0;
                            prev_req  = 0;
                            if (bus_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL bus_unexpected: got request addr 0x%08h, required none", data_sram_addr);
                            end else begin
                                e = bus_q.pop_front();
                                chk("bus_wr",    data_sram_wr,    e.wr);
                                chk("bus_size",  data_sram_size,  e.size);
                                chk("bus_addr",  data_sram_addr,  e.addr);
                                chk("bus_wstrb", data_sram_wstrb, e.wstrb);
                                chk("bus_wdata", data_sram_wdata, e.wdata);
                            end
                        end else begin
                            acnt++;
                            prev_req = 1;
                        end
                    end
                end else begin
                    acnt     = 0;
                    prev_req = 0;
                    aok_lim  = (force_aok >= 0) ? force_aok : int'($urandom_range(0, 3));
                end
            end
        end
    end

    initial begin : out_monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !flush) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got out_valid with rdata 0x%08h, required none", out_rdata);
                end else begin
                    e = out_q.pop_front();
                    chk("out_rdata", out_rdata, e.rdata);
                    chk("out_ale",   out_ale,   e.ale);
                    chk("out_badv",  out_badv,  e.badv);
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Transaction-level reference: decides bus request, result and llbit effect of one access.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit kill_bus, input bit kill_out);
        int          nbytes;
        logic [31:0] eff;
        logic [31:0] word;
        logic [31:0] mask;
        bit          ale;
        bit          is_st;
        bit          is_signed;
        bus_t        b;
        out_t        o;
        if (op == MEM_OP_LD_B || op == MEM_OP_LD_BU || op == MEM_OP_ST_B) nbytes = 1;
        else if (op == MEM_OP_LD_H || op == MEM_OP_LD_HU || op == MEM_OP_ST_H) nbytes = 2;
        else nbytes = 4;
        is_st     = (op == MEM_OP_ST_B || op == MEM_OP_ST_H || op == MEM_OP_ST_W || op == MEM_OP_SC_W);
        is_signed = (op == MEM_OP_LD_B || op == MEM_OP_LD_H);
`ifdef LSU_ALE_CHECK_EN
        ale = (addr % nbytes) != 0;
        eff = addr;
`else
        ale = 1'b0;
        eff = addr - (addr % nbytes);
`endif
        o.rdata = 32'd0; o.ale = 1'b0; o.badv = 32'd0;
        if (ale) begin
            o.ale  = 1'b1;
            o.badv = addr;
        end else if (op == MEM_OP_SC_W && !ref_llbit) begin
            o.rdata = 32'd0;
        end else begin
            b.wr    = is_st;
            b.size  = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
            b.addr  = eff;
            b.wstrb = is_st ? 4'(((1 << nbytes) - 1) << (eff % 4)) : 4'd0;
            if (nbytes == 1)      b.wdata = {4{wd[7:0]}};
            else if (nbytes == 2) b.wdata = {2{wd[15:0]}};
            else                  b.wdata = wd;
            if (!kill_bus) bus_q.push_back(b);
            if (!is_st) begin
                mask = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 1);
                word = (mem_word(eff) >> (8 * (eff % 4))) & mask;
                if (is_signed && word[8 * nbytes - 1]) word = word | ~mask;
                o.rdata = word;
            end else if (op == MEM_OP_SC_W) begin
                o.rdata = 32'd1;
            end
            if (!kill_out) begin
                if (op == MEM_OP_LL_W) ref_llbit = 1'b1;
                if (op == MEM_OP_SC_W) ref_llbit = 1'b0;
            end
        end
        if (!kill_out) out_q.push_back(o);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("timeout_wait_in_ready", in_ready, 1'b1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit kill_bus, input bit kill_out);
        wait_idle();
        model(op, addr, wd, kill_bus, kill_out);
        in_valid  = 1'b1;
        in_mem_op = op;
        in_addr   = addr;
        in_wdata  = wd;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic pulse_clr();
        wait_idle();
        llbit_clr = 1'b1;
        ref_llbit = 1'b0;
        @(posedge clk);
        #1;
        llbit_clr = 1'b0;
    endtask

    initial begin : stim
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        int          n;
        int          seen_valid;
        reset = 1'b1; in_valid = 1'b0; in_mem_op = 4'd0; in_addr = 32'd0; in_wdata = 32'd0;
        flush = 1'b0; llbit_clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_in_ready",  in_ready,        1'b1);
        chk("reset_req",       data_sram_req,   1'b0);
        chk("reset_wstrb",     data_sram_wstrb, 4'd0);
        chk("reset_out_valid", out_valid,       1'b0);
        chk("reset_out_rdata", out_rdata,       32'd0);
        chk("reset_out_ale",   out_ale,         1'b0);
        out_ready = 1'b1;

        issue(MEM_OP_LD_B,  32'h0000_1003, 32'd0, 0, 0);
        issue(MEM_OP_LD_BU, 32'h0000_1003, 32'd0, 0, 0);
        issue(MEM_OP_ST_H,  32'h0000_2002, 32'h0000_BEEF, 0, 0);
        issue(MEM_OP_LL_W,  32'h0000_3000, 32'd0, 0, 0);
        issue(MEM_OP_SC_W,  32'h0000_3000, 32'h1234_5678, 0, 0);
        issue(MEM_OP_SC_W,  32'h0000_3000, 32'h1234_5678, 0, 0);
        issue(MEM_OP_LD_W,  32'h0000_4002, 32'd0, 0, 0);

        // addr_ok withheld for five cycles: request must be held six cycles.
        wait_idle();
        force_aok = 5;
        n = hs_count;
        issue(MEM_OP_ST_W, 32'h0000_5000, 32'hCAFE_F00D, 0, 0);
        for (int i = 0; i < 20 && hs_count == n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("aok_hold_req_cycles", hs_len, 6);

        // Flush in the third request cycle: request gone next cycle, no response.
        wait_idle();
        force_aok = 100;
        issue(MEM_OP_LD_W, 32'h0000_5004, 32'd0, 1, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush_req_cycle3_req", data_sram_req, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_req_dropped", data_sram_req, 1'b0);
        chk("flush_req_in_ready", in_ready, 1'b1);
        force_aok = -1;
        seen_valid = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        chk("flush_req_no_out_valid", seen_valid, 0);

        // Flush in WAIT, data_ok two cycles later: idle right after data_ok, no response.
        force_aok = 0;
        force_dok = 2;
        issue(MEM_OP_LD_W, 32'h0000_5008, 32'd0, 0, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n = 0;
        seen_valid = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
            if (data_sram_data_ok) break;
            n++;
        end
        chk("flush_wait_data_ok_seen", (n < 20), 1'b1);
        @(posedge clk); #1;
        chk("flush_wait_in_ready", in_ready, 1'b1);
        chk("flush_wait_no_out_valid", seen_valid + int'(out_valid), 0);
        force_aok = -1;
        force_dok = -1;

        rand_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 4) == 0) pulse_clr();
            op = 4'($urandom_range(0, 9));
            a  = 32'h0001_0000 | 32'($urandom_range(0, 16'hFFFF));
            wd = $urandom;
            issue(op, a, wd, 0, 0);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        n = 0;
        while ((out_q.size() != 0 || bus_q.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        rand_ready = 1'b0;
        chk("drain_out_queue_empty", out_q.size(), 0);
        chk("drain_bus_queue_empty", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
